// File: rtl/ula_pkg.sv
// ----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the slice-serial ALU: slice width, FSM state type and
// the slice-count helper.
// ----------------------------------------------------------------------------
package ula_pkg;

   localparam int unsigned SLICE_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ula_state_t;

   function automatic int unsigned nslices(input int unsigned width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/ula_74181.sv
// ----------------------------------------------------------------------------
// ula_74181
// One 4-bit 74181-style ALU slice, active-high data and active-high carry.
// Ports:
//   i_a, i_b  : slice operands
//   i_s       : function select
//   i_m       : mode, 1 = logic, 0 = arithmetic
//   i_cin     : carry into bit 0
//   o_f       : slice result
//   o_cout    : carry out of bit 3 (propagated in both modes)
// ----------------------------------------------------------------------------
module ula_74181
   import ula_pkg::*;
(
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic [3:0]         i_s,
   input  logic               i_m,
   input  logic               i_cin,
   output logic [SLICE_W-1:0] o_f,
   output logic               o_cout
);

   logic [SLICE_W-1:0] w_p;
   logic [SLICE_W-1:0] w_g;
   logic [SLICE_W-1:0] w_h;
   logic [SLICE_W-1:0] w_c;
   logic               w_ripple;

   // Per-bit propagate/generate terms selected by S, as in the 74181 input stage.
   assign w_p = i_a | (i_b & {SLICE_W{i_s[0]}}) | (~i_b & {SLICE_W{i_s[1]}});
   assign w_g = (i_a & i_b & {SLICE_W{i_s[3]}}) | (i_a & ~i_b & {SLICE_W{i_s[2]}});
   assign w_h = w_p & ~w_g;

   // Ripple through a scalar so the carry vector has no self-dependency.
   always_comb begin
      w_c      = '0;
      w_ripple = i_cin;
      for (int unsigned i = 0; i < SLICE_W; i++) begin
         w_c[i]   = w_ripple;
         w_ripple = w_g[i] | (w_p[i] & w_ripple);
      end
   end

   assign o_f    = i_m ? ~w_h : (w_h ^ w_c);
   assign o_cout = w_ripple;

endmodule

// File: rtl/ula_serial_n_bits.sv
// ----------------------------------------------------------------------------
// ula_serial_n_bits
// WIDTH-bit ALU built from one 4-bit ula_74181 slice, processed LS slice first
// over WIDTH/4 cycles with the inter-slice carry held in a flop.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, accepted when busy is low
//   a, b, s, m, cin : operands, function select, mode, carry in (captured on accept)
//   busy            : operation in progress
//   done            : one-cycle pulse when f/cout/z have just been updated
//   f, cout, z      : registered result, top-slice carry, zero flag
// ----------------------------------------------------------------------------
module ula_serial_n_bits
   import ula_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] f,
   output logic             cout,
   output logic             z
);

   localparam int unsigned NSLICES = nslices(WIDTH);
   localparam int unsigned CNT_W   = $clog2(NSLICES + 1);

   generate
      if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
         $error("ula_serial_n_bits: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   ula_state_t         r_state;
   ula_state_t         w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_f;
   logic [WIDTH-1:0]   w_acc_next;
   logic [3:0]         r_s;
   logic               r_m;
   logic               r_c;
   logic               r_cout;
   logic               r_z;
   logic               r_done;
   logic [CNT_W-1:0]   r_cnt;
   logic [SLICE_W-1:0] w_slice_f;
   logic               w_slice_cout;
   logic               w_accept;
   logic               w_last;

   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = (r_cnt == CNT_W'(NSLICES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start)  w_next = RUN;
         RUN:     if (w_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   ula_74181 u_slice (
      .i_a    (r_a[SLICE_W-1:0]),
      .i_b    (r_b[SLICE_W-1:0]),
      .i_s    (r_s),
      .i_m    (r_m),
      .i_cin  (r_c),
      .o_f    (w_slice_f),
      .o_cout (w_slice_cout)
   );

   // New slice enters at the top; after NSLICES shifts slice 0 sits at bit 0.
   assign w_acc_next = (r_acc >> SLICE_W) | (WIDTH'(w_slice_f) << (WIDTH - SLICE_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_s    <= '0;
         r_m    <= 1'b0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_f    <= '0;
         r_cout <= 1'b0;
         r_z    <= 1'b1;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_s   <= s;
            r_m   <= m;
            r_c   <= cin;
            r_acc <= '0;
            r_cnt <= '0;
         end else if (r_state == RUN) begin
            r_a   <= r_a >> SLICE_W;
            r_b   <= r_b >> SLICE_W;
            r_acc <= w_acc_next;
            r_c   <= w_slice_cout;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_f    <= w_acc_next;
               r_cout <= w_slice_cout;
               r_z    <= (w_acc_next == '0);
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = (r_state == RUN);
   assign done = r_done;
   assign f    = r_f;
   assign cout = r_cout;
   assign z    = r_z;

endmodule

// File: tb/tb_ula_serial_n_bits.sv
// ----------------------------------------------------------------------------
// tb_ula_serial_n_bits
// Scoreboard bench for ula_serial_n_bits at WIDTH = 4, 8, 16 and 32.
// Expected results come from a datasheet-function model of the 74181
// (each select code expressed as X plus Y plus carry, plus its logic function).
// ----------------------------------------------------------------------------
module tb_ula_serial_n_bits;

   typedef struct packed {
      logic [31:0] f;
      logic        c;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic [3:0]  s   = 4'b1001;
   logic        m   = 1'b0;
   logic        cin = 1'b0;
   logic        st_4 = 1'b0, st_8 = 1'b0, st_16 = 1'b0, st_32 = 1'b0;

   logic        busy_4, busy_8, busy_16, busy_32;
   logic        done_4, done_8, done_16, done_32;
   logic        cout_4, cout_8, cout_16, cout_32;
   logic        z_4, z_8, z_16, z_32;
   logic [3:0]  f_4;
   logic [7:0]  f_8;
   logic [15:0] f_16;
   logic [31:0] f_32;

   exp_t q4[$], q8[$], q16[$], q32[$];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   ula_serial_n_bits #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(st_4), .a(a32[3:0]), .b(b32[3:0]), .s(s), .m(m), .cin(cin),
      .busy(busy_4), .done(done_4), .f(f_4), .cout(cout_4), .z(z_4));
   ula_serial_n_bits #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(st_8), .a(a32[7:0]), .b(b32[7:0]), .s(s), .m(m), .cin(cin),
      .busy(busy_8), .done(done_8), .f(f_8), .cout(cout_8), .z(z_8));
   ula_serial_n_bits #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(st_16), .a(a32[15:0]), .b(b32[15:0]), .s(s), .m(m), .cin(cin),
      .busy(busy_16), .done(done_16), .f(f_16), .cout(cout_16), .z(z_16));
   ula_serial_n_bits #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .start(st_32), .a(a32), .b(b32), .s(s), .m(m), .cin(cin),
      .busy(busy_32), .done(done_32), .f(f_32), .cout(cout_32), .z(z_32));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // 74181 functions used here: arithmetic result is X plus Y plus cin.
   function automatic exp_t golden(input int unsigned w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic [3:0] sv, input logic mv, input logic cv);
      exp_t        e;
      logic [31:0] mask, xa, ya, lg;
      logic [32:0] sum;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      case (sv)
         4'b1001: begin xa = av;      ya = bv;           lg = ~(av ^ bv); end
         4'b0110: begin xa = av;      ya = ~bv;          lg = av ^ bv;    end
         4'b1011: begin xa = av & bv; ya = 32'hFFFF_FFFF; lg = av & bv;   end
         default: begin xa = av;      ya = 32'h0;        lg = ~av;        end
      endcase
      sum = {1'b0, xa & mask} + {1'b0, ya & mask} + 33'(cv);
      e.f = (mv ? lg : sum[31:0]) & mask;
      e.c = sum[w];
      e.z = (e.f == 32'h0);
      return e;
   endfunction

   task automatic mon(input string w, input exp_t e, input logic [31:0] fo, input logic co, input logic zo);
      chk({"f_w", w},    64'(fo), 64'(e.f));
      chk({"cout_w", w}, 64'(co), 64'(e.c));
      chk({"z_w", w},    64'(zo), 64'(e.z));
   endtask

   always @(negedge clk) if (!rst && done_4) begin
      if (q4.size() == 0) chk("spurious_done_w4", 64'(done_4), 64'(0));
      else mon("4", q4.pop_front(), 32'(f_4), cout_4, z_4);
   end
   always @(negedge clk) if (!rst && done_8) begin
      if (q8.size() == 0) chk("spurious_done_w8", 64'(done_8), 64'(0));
      else mon("8", q8.pop_front(), 32'(f_8), cout_8, z_8);
   end
   always @(negedge clk) if (!rst && done_16) begin
      if (q16.size() == 0) chk("spurious_done_w16", 64'(done_16), 64'(0));
      else mon("16", q16.pop_front(), 32'(f_16), cout_16, z_16);
   end
   always @(negedge clk) if (!rst && done_32) begin
      if (q32.size() == 0) chk("spurious_done_w32", 64'(done_32), 64'(0));
      else mon("32", q32.pop_front(), f_32, cout_32, z_32);
   end

   // One WIDTH=16 operation from an idle negedge; checks latency, busy length
   // and that f/cout hold their old values while busy. Returns on the negedge
   // after the done cycle.
   task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic [3:0] sv,
                        input logic mv, input logic cv);
      logic [15:0] old_f;
      logic        old_c;
      int          busy_cnt, done_k;
      old_f = f_16;
      old_c = cout_16;
      a32 = {16'h0, av}; b32 = {16'h0, bv}; s = sv; m = mv; cin = cv;
      st_16 = 1'b1;
      q16.push_back(golden(16, a32, b32, sv, mv, cv));
      @(posedge clk); #1 st_16 = 1'b0;
      busy_cnt = 0;
      done_k   = 0;
      for (int k = 1; k <= 20 && done_k == 0; k++) begin
         @(negedge clk);
         if (done_16) begin
            done_k = k;
            chk("busy_at_done", 64'(busy_16), 64'(0));
         end else if (busy_16) begin
            busy_cnt++;
            chk("hold_f", 64'(f_16), 64'(old_f));
            chk("hold_cout", 64'(cout_16), 64'(old_c));
         end
      end
      chk("latency_w16", 64'(done_k - 1), 64'(4));
      chk("busy_cycles_w16", 64'(busy_cnt), 64'(4));
      @(negedge clk);
      chk("done_width", 64'(done_16), 64'(0));
   endtask

   // Same random operands to all four widths at once.
   task automatic rand_all(input logic [3:0] sv, input logic mv);
      bit seen;
      a32 = $urandom; b32 = $urandom; cin = 1'($urandom_range(0, 1)); s = sv; m = mv;
      q4.push_back(golden(4, a32, b32, sv, mv, cin));
      q8.push_back(golden(8, a32, b32, sv, mv, cin));
      q16.push_back(golden(16, a32, b32, sv, mv, cin));
      q32.push_back(golden(32, a32, b32, sv, mv, cin));
      {st_4, st_8, st_16, st_32} = 4'b1111;
      @(posedge clk); #1 {st_4, st_8, st_16, st_32} = 4'b0000;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (done_32) seen = 1'b1;
      end
      if (!seen) chk("rand_timeout_w32", 64'(done_32), 64'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   initial begin
      logic [3:0] sel_tab [4];
      int         n, last, dn;
      sel_tab = '{4'b0000, 4'b0110, 4'b1001, 4'b1011};

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy_16), 64'(0));
      chk("rst_done", 64'(done_16), 64'(0));
      chk("rst_f", 64'(f_16), 64'(0));
      chk("rst_cout", 64'(cout_16), 64'(0));
      chk("rst_z", 64'(z_16), 64'(1));
      chk("rst_z_w4", 64'(z_4), 64'(1));
      rst = 1'b0;
      @(negedge clk);

      run16(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0);
      chk("xor_f", 64'(f_16), 64'h0FF0);
      chk("xor_z", 64'(z_16), 64'(0));

      run16(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b1);
      chk("ripple_f", 64'(f_16), 64'h0000);
      chk("ripple_cout", 64'(cout_16), 64'(1));
      chk("ripple_z", 64'(z_16), 64'(1));

      run16(16'h1234, 16'h0000, 4'b1011, 1'b1, 1'b0);
      chk("and_f", 64'(f_16), 64'h0000);
      chk("and_z", 64'(z_16), 64'(1));

      // start held high: back-to-back operations every 5 cycles
      a32 = 32'h0000_1111; b32 = 32'h0000_2222; s = 4'b1001; m = 1'b0; cin = 1'b0;
      st_16 = 1'b1;
      q16.push_back(golden(16, a32, b32, s, m, cin));
      n = 0; last = 0;
      for (int k = 0; k < 40 && n < 3; k++) begin
         @(negedge clk);
         if (done_16) begin
            if (n > 0) chk("b2b_spacing", 64'(k - last), 64'(5));
            last = k;
            n++;
            if (n < 3) begin
               a32 = a32 + 32'h0000_7531; b32 = b32 ^ 32'h0000_9C9C; cin = ~cin;
               q16.push_back(golden(16, a32, b32, s, m, cin));
            end else begin
               st_16 = 1'b0;
            end
         end
      end
      chk("b2b_count", 64'(n), 64'(3));
      @(negedge clk);
      chk("b2b_stop_busy", 64'(busy_16), 64'(0));

      // start while busy is ignored and later input changes do not matter
      a32 = 32'h0000_1234; b32 = 32'h0000_4321; s = 4'b1001; m = 1'b0; cin = 1'b0;
      st_16 = 1'b1;
      q16.push_back(golden(16, a32, b32, s, m, cin));
      @(posedge clk); #1 st_16 = 1'b0;
      repeat (2) @(negedge clk);
      a32 = 32'h0000_ABCD; b32 = 32'h0000_0F0F; s = 4'b0110; m = 1'b1; cin = 1'b1;
      st_16 = 1'b1;
      @(negedge clk);
      st_16 = 1'b0;
      dn = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done_16) dn++;
      end
      chk("ignore_done_count", 64'(dn), 64'(1));
      chk("ignore_f", 64'(f_16), 64'h5555);

      // reset during slice 2
      a32 = 32'h0000_00FF; b32 = 32'h0000_0F0F; s = 4'b1001; m = 1'b0; cin = 1'b0;
      st_16 = 1'b1;
      q16.push_back(golden(16, a32, b32, s, m, cin));
      @(posedge clk); #1 st_16 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy_16), 64'(0));
      chk("abort_done", 64'(done_16), 64'(0));
      chk("abort_f", 64'(f_16), 64'(0));
      chk("abort_cout", 64'(cout_16), 64'(0));
      chk("abort_z", 64'(z_16), 64'(1));
      q16.delete();
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done_16) dn++;
      end
      chk("abort_no_done", 64'(dn), 64'(0));
      run16(16'h8001, 16'h8001, 4'b1001, 1'b0, 1'b0);
      chk("after_abort_f", 64'(f_16), 64'h0002);
      chk("after_abort_cout", 64'(cout_16), 64'(1));

      // WIDTH=4 completes one edge after acceptance
      a32 = 32'h0000_0009; b32 = 32'h0000_0008; s = 4'b1001; m = 1'b0; cin = 1'b1;
      st_4 = 1'b1;
      q4.push_back(golden(4, a32, b32, s, m, cin));
      @(posedge clk); #1 st_4 = 1'b0;
      @(negedge clk);
      chk("latency_w4_busy", 64'(busy_4), 64'(1));
      @(negedge clk);
      chk("latency_w4_done", 64'(done_4), 64'(1));
      chk("w4_f", 64'(f_4), 64'h2);
      chk("w4_cout", 64'(cout_4), 64'(1));
      @(negedge clk);

      for (int i = 0; i < 1000; i++) rand_all(4'b1001, 1'b0);
      for (int i = 0; i < 200; i++) rand_all(sel_tab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      repeat (3) @(negedge clk);

      chk("sb_drain_w4", 64'(q4.size()), 64'(0));
      chk("sb_drain_w8", 64'(q8.size()), 64'(0));
      chk("sb_drain_w16", 64'(q16.size()), 64'(0));
      chk("sb_drain_w32", 64'(q32.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
